// File: rtl/fps_pkg.sv
// Shared constants and types for the frame-rate counter and other timebase users.
package fps_pkg;

    // BCD layout of the debug display value
    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_DIGITS  = 3;
    localparam int BCD_W       = BCD_DIGIT_W * BCD_DIGITS;

    // Board clock cycles in one second, calibrated against the 16 MHz oscillator
    localparam int CLOCKS_PER_SEC_DEFAULT = 15998100;

    // Binary-to-BCD converter states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        r = bcd;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (r[d*BCD_DIGIT_W +: BCD_DIGIT_W] >= 4'd5) begin
                r[d*BCD_DIGIT_W +: BCD_DIGIT_W] = r[d*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fps_counter_if.sv
// Signal bundle between the frame-rate counter and the capture / display side.
//
// Handshake: BCD_VALID is a one-cycle strobe with no back-pressure (there is no
// ready). FPS_BCD is valid in the strobe cycle and stays stable until the next
// strobe. SEC_TICK is likewise a one-cycle strobe. CONV_STATE is a debug view
// of the converter FSM.
interface fps_counter_if #(
    parameter int COUNT_W = 8
);
    import fps_pkg::*;

    logic               VSYNC_IN;
    logic               SEC_TICK;
    logic               LED_OUT;
    logic [COUNT_W-1:0] FPS_COUNT;
    logic [BCD_W-1:0]   FPS_BCD;
    logic               BCD_VALID;
    logic               OVERFLOW;
    conv_state_t        CONV_STATE;

    modport master (
        input  VSYNC_IN,
        output SEC_TICK, LED_OUT, FPS_COUNT, FPS_BCD, BCD_VALID, OVERFLOW, CONV_STATE
    );

    modport slave (
        output VSYNC_IN,
        input  SEC_TICK, LED_OUT, FPS_COUNT, FPS_BCD, BCD_VALID, OVERFLOW, CONV_STATE
    );

endinterface

// File: rtl/fps_counter_bin2bcd_seq.sv
// Sequential double-dabble converter: one binary bit per cycle, three BCD digits out.
module bin2bcd_seq
    import fps_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               CLK16MHz,
    input  logic               RESET,
    input  logic               start,
    input  logic [COUNT_W-1:0] value,
    output logic [BCD_W-1:0]   bcd,
    output logic               valid,
    output conv_state_t        state
);

    localparam int SH_W  = BCD_W + COUNT_W;
    localparam int CNT_W = $clog2(COUNT_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(COUNT_W - 1);

    conv_state_t       state_q, state_d;
    logic [SH_W-1:0]   sh_q, sh_adj;
    logic [CNT_W-1:0]  bit_q;
    logic [BCD_W-1:0]  bcd_q;
    logic              valid_q;
    logic              load, shift, done;

    // State register
    always_ff @(posedge CLK16MHz or posedge RESET) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: the last shift is the one taken while bit_q == COUNT_W-1
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (bit_q == LAST_BIT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/control decode from the current state
    always_comb begin
        load  = (state_q == IDLE) && start;
        shift = (state_q == SHIFT);
        done  = (state_q == DONE);
    end

    // Correct the BCD digits before each shift
    always_comb begin
        sh_adj = {bcd_adjust(sh_q[SH_W-1 -: BCD_W]), sh_q[COUNT_W-1:0]};
    end

    // Shift register, bit counter and held result
    always_ff @(posedge CLK16MHz or posedge RESET) begin
        if (RESET) begin
            sh_q    <= '0;
            bit_q   <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= done;
            if (load) begin
                sh_q  <= {{BCD_W{1'b0}}, value};
                bit_q <= '0;
            end else if (shift) begin
                sh_q  <= sh_adj << 1;
                bit_q <= bit_q + 1'b1;
            end
            if (done) bcd_q <= sh_q[SH_W-1 -: BCD_W];
        end
    end

    assign bcd   = bcd_q;
    assign valid = valid_q;
    assign state = state_q;

endmodule

// File: rtl/fps_counter.sv
// Frame-rate meter: counts VSYNC rising edges per one-second window and
// presents the result in binary and BCD.
module fps_counter
    import fps_pkg::*;
#(
    parameter int CLOCKS_PER_SEC = CLOCKS_PER_SEC_DEFAULT,
    parameter int COUNT_W        = 8
) (
    input  logic          CLK16MHz,
    input  logic          RESET,
    fps_counter_if.master bus
);

    localparam int WIN_W = (CLOCKS_PER_SEC > 1) ? $clog2(CLOCKS_PER_SEC) : 1;
    localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(CLOCKS_PER_SEC - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX  = '1;

    logic               vsync_s1, vsync_s2, vsync_d, frame_pulse;
    logic [WIN_W-1:0]   win_cnt;
    logic               sec_tick;
    logic [COUNT_W-1:0] frame_cnt, frame_sum;
    logic [COUNT_W-1:0] fps_q;
    logic               ovf_q, led_q;

    // Two-stage synchroniser and registered rising-edge detector (3-cycle lag)
    always_ff @(posedge CLK16MHz or posedge RESET) begin
        if (RESET) begin
            vsync_s1    <= 1'b0;
            vsync_s2    <= 1'b0;
            vsync_d     <= 1'b0;
            frame_pulse <= 1'b0;
        end else begin
            vsync_s1    <= bus.VSYNC_IN;
            vsync_s2    <= vsync_s1;
            vsync_d     <= vsync_s2;
            frame_pulse <= vsync_s2 & ~vsync_d;
        end
    end

    // Window timebase: counts 0..CLOCKS_PER_SEC-1 and wraps
    always_ff @(posedge CLK16MHz or posedge RESET) begin
        if (RESET)         win_cnt <= '0;
        else if (sec_tick) win_cnt <= '0;
        else               win_cnt <= win_cnt + 1'b1;
    end

    assign sec_tick = (win_cnt == WIN_LAST);

    // Running count including this cycle's pulse, saturating at all-ones
    always_comb begin
        frame_sum = frame_cnt;
        if (frame_pulse && (frame_cnt != CNT_MAX)) frame_sum = frame_cnt + 1'b1;
    end

    // Frame counter and end-of-window latch; a pulse on the tick cycle closes with the old window
    always_ff @(posedge CLK16MHz or posedge RESET) begin
        if (RESET) begin
            frame_cnt <= '0;
            fps_q     <= '0;
            ovf_q     <= 1'b0;
            led_q     <= 1'b0;
        end else if (sec_tick) begin
            frame_cnt <= '0;
            fps_q     <= frame_sum;
            ovf_q     <= (frame_sum == CNT_MAX);
            led_q     <= ~led_q;
        end else begin
            frame_cnt <= frame_sum;
        end
    end

    bin2bcd_seq #(
        .COUNT_W (COUNT_W)
    ) u_bin2bcd (
        .CLK16MHz (CLK16MHz),
        .RESET    (RESET),
        .start    (sec_tick),
        .value    (frame_sum),
        .bcd      (bus.FPS_BCD),
        .valid    (bus.BCD_VALID),
        .state    (bus.CONV_STATE)
    );

    assign bus.SEC_TICK  = sec_tick;
    assign bus.LED_OUT   = led_q;
    assign bus.FPS_COUNT = fps_q;
    assign bus.OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_fps_counter.sv
// Directed bench for fps_counter: a 100-cycle-window instance for timing,
// reset and boundary cases, and a 1000-cycle-window instance for large counts.
module tb_fps_counter;
    import fps_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel_b = 1'b0;
    int   checks = 0;
    int   failures = 0;

    fps_counter_if #(.COUNT_W(8)) ifa ();
    fps_counter_if #(.COUNT_W(8)) ifb ();

    fps_counter #(.CLOCKS_PER_SEC(100), .COUNT_W(8)) dut_a (
        .CLK16MHz (clk),
        .RESET    (rst),
        .bus      (ifa)
    );

    fps_counter #(.CLOCKS_PER_SEC(1000), .COUNT_W(8)) dut_b (
        .CLK16MHz (clk),
        .RESET    (rst),
        .bus      (ifb)
    );

    // Clock
    always #5 clk = ~clk;

    // Observation mux: tasks look at whichever instance is selected
    logic        obs_tick, obs_led, obs_valid, obs_ovf;
    logic [7:0]  obs_count;
    logic [11:0] obs_bcd;
    conv_state_t obs_state;
    assign obs_tick  = sel_b ? ifb.SEC_TICK   : ifa.SEC_TICK;
    assign obs_led   = sel_b ? ifb.LED_OUT    : ifa.LED_OUT;
    assign obs_valid = sel_b ? ifb.BCD_VALID  : ifa.BCD_VALID;
    assign obs_ovf   = sel_b ? ifb.OVERFLOW   : ifa.OVERFLOW;
    assign obs_count = sel_b ? ifb.FPS_COUNT  : ifa.FPS_COUNT;
    assign obs_bcd   = sel_b ? ifb.FPS_BCD    : ifa.FPS_BCD;
    assign obs_state = sel_b ? ifb.CONV_STATE : ifa.CONV_STATE;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vs(input logic v);
        if (sel_b) ifb.VSYNC_IN = v;
        else       ifa.VSYNC_IN = v;
    endtask

    // n clean rising edges, one cycle high / one cycle low
    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            set_vs(1'b1);
            tick();
            set_vs(1'b0);
            tick();
        end
    endtask

    // n rising edges off the clock grid, each level held 25..45 time units
    task automatic jitter_pulses(input int n);
        #($urandom_range(1, 9));
        for (int i = 0; i < n; i++) begin
            set_vs(1'b1);
            #($urandom_range(25, 45));
            set_vs(1'b0);
            #($urandom_range(25, 45));
        end
    endtask

    // Step until SEC_TICK is seen, bounded
    task automatic wait_tick(input string tag, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (obs_tick) begin
                found = 1'b1;
                break;
            end
        end
        chk({tag, "_tick_found"}, 32'(found), 32'd1);
    endtask

    // Called in the SEC_TICK cycle: checks the latch one edge later and the
    // BCD strobe exactly 10 cycles later, lasting one cycle
    task automatic after_tick(input string tag, input int exp_count, input logic exp_led,
                              input logic exp_ovf, input logic [11:0] exp_bcd);
        logic early;
        early = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) begin
                chk({tag, "_count"}, 32'(obs_count), 32'(exp_count));
                chk({tag, "_led"},   32'(obs_led),   32'(exp_led));
                chk({tag, "_ovf"},   32'(obs_ovf),   32'(exp_ovf));
            end
            if (k < 10) early = early | obs_valid;
        end
        chk({tag, "_valid_early"}, 32'(early), 32'd0);
        chk({tag, "_valid_at10"},  32'(obs_valid), 32'd1);
        chk({tag, "_bcd"},         32'(obs_bcd), 32'(exp_bcd));
        tick();
        chk({tag, "_valid_drop"},  32'(obs_valid), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_count"}, 32'(obs_count), 32'd0);
        chk({tag, "_bcd"},   32'(obs_bcd),   32'd0);
        chk({tag, "_led"},   32'(obs_led),   32'd0);
        chk({tag, "_ovf"},   32'(obs_ovf),   32'd0);
        chk({tag, "_valid"}, 32'(obs_valid), 32'd0);
        chk({tag, "_tick"},  32'(obs_tick),  32'd0);
        chk({tag, "_state"}, 32'(obs_state), 32'(IDLE));
    endtask

    // Hard stop if something wedges
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen_tick, seen_valid;
        int   n_rand;
        logic [11:0] exp_bcd;

        ifa.VSYNC_IN = 1'b0;
        ifb.VSYNC_IN = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (5) tick();
        check_all_zero("reset");
        rst = 1'b0;

        // First tick exactly on cycle 99, then three empty windows: LED 1,0,1
        seen_tick = 1'b0;
        for (int i = 0; i < 98; i++) begin
            tick();
            seen_tick = seen_tick | obs_tick;
        end
        chk("w1_tick_early", 32'(seen_tick), 32'd0);
        tick();
        chk("w1_tick_99", 32'(obs_tick), 32'd1);
        after_tick("w1", 0, 1'b1, 1'b0, 12'h000);
        wait_tick("w2", 200);
        after_tick("w2", 0, 1'b0, 1'b0, 12'h000);
        wait_tick("w3", 200);
        after_tick("w3", 0, 1'b1, 1'b0, 12'h000);

        // Four early pulses plus one landing on the tick cycle itself -> 5
        wait_tick("w4", 200);
        pulses(4);
        repeat (89) tick();
        set_vs(1'b1);
        repeat (3) tick();
        chk("coin_tick", 32'(obs_tick), 32'd1);
        after_tick("coin", 5, 1'b1, 1'b0, 12'h005);
        set_vs(1'b0);
        wait_tick("coin_next", 200);
        after_tick("coin_next", 0, 1'b0, 1'b0, 12'h000);

        // Reset during SHIFT, then reset mid-window
        pulses(3);
        wait_tick("rst_pre", 200);
        repeat (4) tick();
        chk("rst_pre_count", 32'(obs_count), 32'd3);
        chk("rst_pre_state", 32'(obs_state), 32'(SHIFT));
        rst = 1'b1;
        #1;
        check_all_zero("rst_shift");
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen_valid = seen_valid | obs_valid;
        end
        chk("rst_hold_valid", 32'(seen_valid), 32'd0);
        rst = 1'b0;
        repeat (40) tick();
        pulses(2);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        tick();
        tick();
        rst = 1'b0;
        seen_tick = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 98; i++) begin
            tick();
            seen_tick  = seen_tick | obs_tick;
            seen_valid = seen_valid | obs_valid;
        end
        chk("rst_tick_early", 32'(seen_tick), 32'd0);
        chk("rst_no_late_valid", 32'(seen_valid), 32'd0);
        tick();
        chk("rst_tick_99", 32'(obs_tick), 32'd1);
        after_tick("rst_win", 0, 1'b1, 1'b0, 12'h000);

        // Large-window instance
        sel_b = 1'b1;
        wait_tick("b_w1", 1100);
        pulses(60);
        wait_tick("b60", 1100);
        after_tick("b60", 60, 1'b0, 1'b0, 12'h060);
        pulses(300);
        wait_tick("b300", 1100);
        after_tick("b300", 255, 1'b1, 1'b1, 12'h255);
        pulses(59);
        wait_tick("b59", 1100);
        after_tick("b59", 59, 1'b0, 1'b0, 12'h059);

        // Asynchronous edges with random phase and width
        n_rand = int'($urandom_range(20, 80));
        exp_bcd = {4'(n_rand / 100), 4'((n_rand / 10) % 10), 4'(n_rand % 10)};
        jitter_pulses(n_rand);
        wait_tick("brand", 1100);
        after_tick("brand", n_rand, 1'b1, 1'b0, exp_bcd);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
